vga_text_blit_engine: RTL and testbench

- Command-driven fill/copy engine on main_clk, directly upstream of vga_memory_system's io port.
- Owns the io_* bus toward VGA memory. Forwards host (CPU) accesses when idle and stalls them while a command runs.
- Provides hardware text-cell clears and scrolls, so software no longer issues one byte write per cell.
- Text layout: cell k occupies byte addresses 3k (char), 3k+1 (fg), 3k+2 (bg); 20476..20479 are config bytes.

---
 rtl/vga_blit_pkg.sv | 31 +++
 rtl/vga_text_blit_engine_if.sv | 55 +++++
 rtl/vga_text_blit_engine.sv | 170 +++++++++++++++++
 tb/tb_vga_text_blit_engine.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_blit_pkg.sv
// ============================================================================
// vga_blit_pkg : shared types and constants for the VGA text blit engine
// Rev 1.0
// ============================================================================
`default_nettype none

package vga_blit_pkg;

  localparam int VGA_TEXT_LIMIT     = 20476;
  localparam int VGA_BYTES_PER_CELL = 3;

  typedef enum logic {
    OP_FILL = 1'b0,
    OP_COPY = 1'b1
  } op_e;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    F_CH = 4'd1,
    F_FG = 4'd2,
    F_BG = 4'd3,
    C_RD = 4'd4,
    C_W  = 4'd5,
    C_WR = 4'd6,
    DONE = 4'd7,
    ERR  = 4'd8
  } state_e;

endpackage

`default_nettype wire

// File: rtl/vga_text_blit_engine_if.sv
// ============================================================================
// vga_text_blit_engine_if : command, host and VGA-memory bus of the blit engine
// Rev 1.0
// ============================================================================
`default_nettype none

interface vga_text_blit_engine_if #(
  parameter int COUNT_W = 13
);

  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_op;
  logic [14:0]        cmd_dst;
  logic [14:0]        cmd_src;
  logic [COUNT_W-1:0] cmd_count;
  logic [7:0]         cmd_char;
  logic [7:0]         cmd_fg;
  logic [7:0]         cmd_bg;
  logic               busy;
  logic               done;
  logic               err;

  logic               host_do_write;
  logic               host_do_byte_op;
  logic [14:0]        host_addr;
  logic [15:0]        host_write_data;
  logic               host_wait;

  logic               io_do_write;
  logic               io_do_byte_op;
  logic [14:0]        io_addr;
  logic [15:0]        io_write_data;
  logic [15:0]        io_read_data;

  // System side: CPU, command source and the VGA memory read path
  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_count, cmd_char, cmd_fg, cmd_bg,
    output host_do_write, host_do_byte_op, host_addr, host_write_data,
    output io_read_data,
    input  cmd_ready, busy, done, err, host_wait,
    input  io_do_write, io_do_byte_op, io_addr, io_write_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_count, cmd_char, cmd_fg, cmd_bg,
    input  host_do_write, host_do_byte_op, host_addr, host_write_data,
    input  io_read_data,
    output cmd_ready, busy, done, err, host_wait,
    output io_do_write, io_do_byte_op, io_addr, io_write_data
  );

endinterface

`default_nettype wire

// File: rtl/vga_text_blit_engine.sv
// ============================================================================
// vga_text_blit_engine : FILL/COPY engine for text cells, muxed with host access
// Rev 1.0
// ============================================================================
`default_nettype none

module vga_text_blit_engine
  import vga_blit_pkg::*;
#(
  parameter int TEXT_LIMIT   = VGA_TEXT_LIMIT,
  parameter int READ_LATENCY = 2,
  parameter int COUNT_W      = 13
) (
  input  wire logic             main_clk,
  input  wire logic             main_rst_n,
  vga_text_blit_engine_if.slave bus
);

  localparam int WAIT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  state_e             r_state;
  state_e             w_next;
  logic               r_desc;
  logic [14:0]        r_dst;
  logic [14:0]        r_src;
  logic [COUNT_W-1:0] r_cnt;
  logic [7:0]         r_char;
  logic [7:0]         r_fg;
  logic [7:0]         r_bg;
  logic [7:0]         r_cap;
  logic [WAIT_W-1:0]  r_wait;

  logic        w_is_copy;
  logic        w_zero;
  logic        w_bad;
  logic        w_desc;
  logic        w_last_cnt;
  logic        w_last_wait;
  logic        w_busy;
  logic [14:0] w_max;
  logic [16:0] w_fill_end;
  logic [16:0] w_copy_end;

  // Validation runs on the raw command inputs so it is resolved in the accept cycle
  assign w_is_copy   = (op_e'(bus.cmd_op) == OP_COPY);
  assign w_zero      = (bus.cmd_count == '0);
  assign w_desc      = (bus.cmd_dst > bus.cmd_src);
  assign w_max       = w_desc ? bus.cmd_dst : bus.cmd_src;
  assign w_fill_end  = {2'b00, bus.cmd_dst} + 17'(VGA_BYTES_PER_CELL) * 17'(bus.cmd_count) - 17'd1;
  assign w_copy_end  = {2'b00, w_max} + 17'(bus.cmd_count) - 17'd1;
  assign w_bad       = (w_is_copy ? w_copy_end : w_fill_end) >= 17'(TEXT_LIMIT);
  assign w_last_cnt  = (r_cnt == COUNT_W'(1));
  assign w_last_wait = (r_wait == WAIT_W'(READ_LATENCY - 1));
  assign w_busy      = (r_state inside {F_CH, F_FG, F_BG, C_RD, C_W, C_WR});

  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (w_zero)         w_next = DONE;
          else if (w_bad)     w_next = ERR;
          else if (w_is_copy) w_next = C_RD;
          else                w_next = F_CH;
        end
      end
      F_CH:    w_next = F_FG;
      F_FG:    w_next = F_BG;
      F_BG:    w_next = w_last_cnt ? DONE : F_CH;
      C_RD:    w_next = C_W;
      C_W:     w_next = w_last_wait ? C_WR : C_W;
      C_WR:    w_next = w_last_cnt ? DONE : C_RD;
      DONE:    w_next = IDLE;
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      r_desc <= 1'b0;
      r_dst  <= '0;
      r_src  <= '0;
      r_cnt  <= '0;
      r_char <= '0;
      r_fg   <= '0;
      r_bg   <= '0;
      r_cap  <= '0;
      r_wait <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.cmd_valid) begin
            r_cnt  <= bus.cmd_count;
            r_char <= bus.cmd_char;
            r_fg   <= bus.cmd_fg;
            r_bg   <= bus.cmd_bg;
            r_desc <= w_is_copy && w_desc;
            // Descending copies start at the last byte so overlapping scroll-down is safe
            if (w_is_copy && w_desc) begin
              r_dst <= bus.cmd_dst + 15'(bus.cmd_count) - 15'd1;
              r_src <= bus.cmd_src + 15'(bus.cmd_count) - 15'd1;
            end else begin
              r_dst <= bus.cmd_dst;
              r_src <= bus.cmd_src;
            end
          end
        end
        F_CH, F_FG: r_dst <= r_dst + 15'd1;
        F_BG: begin
          r_dst <= r_dst + 15'd1;
          r_cnt <= r_cnt - COUNT_W'(1);
        end
        C_RD: r_wait <= '0;
        C_W: begin
          r_wait <= r_wait + WAIT_W'(1);
          if (w_last_wait) begin
            r_cap <= r_src[0] ? bus.io_read_data[15:8] : bus.io_read_data[7:0];
          end
        end
        C_WR: begin
          r_dst <= r_desc ? r_dst - 15'd1 : r_dst + 15'd1;
          r_src <= r_desc ? r_src - 15'd1 : r_src + 15'd1;
          r_cnt <= r_cnt - COUNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Host traffic passes straight through whenever no engine access is in flight
  always_comb begin
    bus.cmd_ready     = main_rst_n && (r_state == IDLE);
    bus.busy          = w_busy;
    bus.host_wait     = w_busy;
    bus.done          = (r_state == DONE);
    bus.err           = (r_state == ERR);
    bus.io_do_write   = main_rst_n && bus.host_do_write;
    bus.io_do_byte_op = main_rst_n && bus.host_do_byte_op;
    bus.io_addr       = main_rst_n ? bus.host_addr : '0;
    bus.io_write_data = main_rst_n ? bus.host_write_data : '0;
    if (w_busy) begin
      bus.io_do_byte_op = 1'b1;
      bus.io_do_write   = 1'b1;
      bus.io_addr       = r_dst;
      bus.io_write_data = '0;
      case (r_state)
        F_CH: bus.io_write_data = {r_char, r_char};
        F_FG: bus.io_write_data = {r_fg, r_fg};
        F_BG: bus.io_write_data = {r_bg, r_bg};
        C_WR: bus.io_write_data = {r_cap, r_cap};
        default: begin
          bus.io_do_write = 1'b0;
          bus.io_addr     = r_src;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_text_blit_engine.sv
// ============================================================================
// tb_vga_text_blit_engine : directed checks of host pass-through, FILL, COPY, errors
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vga_text_blit_engine;

  typedef struct {
    int          cyc;
    logic [14:0] addr;
    logic [15:0] data;
    logic        byte_op;
  } wr_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;
  int   done_cnt;
  int   done_cyc;
  int   err_cnt;
  int   err_cyc;
  wr_t  wr_log[$];
  logic [7:0]  mem [0:32767];
  logic [15:0] rd1;
  logic [15:0] rd2;

  vga_text_blit_engine_if #(.COUNT_W(13)) bus ();

  vga_text_blit_engine #(
    .TEXT_LIMIT  (20476),
    .READ_LATENCY(2),
    .COUNT_W     (13)
  ) dut (
    .main_clk  (clk),
    .main_rst_n(rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-stage read pipeline standing in for vga_memory_system
  assign bus.io_read_data = rd2;
  always @(posedge clk) begin
    rd1 <= {mem[{bus.io_addr[14:1], 1'b1}], mem[{bus.io_addr[14:1], 1'b0}]};
    rd2 <= rd1;
    if (bus.io_do_write) begin
      if (bus.io_do_byte_op) begin
        mem[bus.io_addr] = bus.io_addr[0] ? bus.io_write_data[15:8] : bus.io_write_data[7:0];
      end else begin
        mem[{bus.io_addr[14:1], 1'b0}] = bus.io_write_data[7:0];
        mem[{bus.io_addr[14:1], 1'b1}] = bus.io_write_data[15:8];
      end
    end
  end

  always @(posedge clk) begin
    if (bus.io_do_write) wr_log.push_back('{cyc, bus.io_addr, bus.io_write_data, bus.io_do_byte_op});
    if (bus.done) begin done_cnt++; done_cyc = cyc; end
    if (bus.err)  begin err_cnt++;  err_cyc  = cyc; end
    cyc++;
  end

  task automatic issue(input bit op, input logic [14:0] dst, input logic [14:0] src,
                       input logic [12:0] cnt, input logic [7:0] ch, input logic [7:0] fg,
                       input logic [7:0] bg, output int t);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_dst   = dst;
    bus.cmd_src   = src;
    bus.cmd_count = cnt;
    bus.cmd_char  = ch;
    bus.cmd_fg    = fg;
    bus.cmd_bg    = bg;
    t = cyc;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_ready(input int max, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < max; i++) begin
      if (bus.cmd_ready === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    total++;
    if ({bus.busy, bus.done, bus.err, bus.host_wait, bus.io_do_write, bus.io_do_byte_op} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000000",
               {bus.busy, bus.done, bus.err, bus.host_wait, bus.io_do_write, bus.io_do_byte_op});
    end
    total++;
    if ({bus.io_addr, bus.io_write_data} !== 31'd0) begin
      bad++;
      $display("FAIL reset_bus addr=%0d data=%h want 0/0", bus.io_addr, bus.io_write_data);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    total++;
    if (bus.cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got=%b want=1", bus.cmd_ready);
    end
  endtask

  task automatic test_host_idle();
    bus.host_do_write   = 1'b1;
    bus.host_addr       = 15'd100;
    bus.host_write_data = 16'hBEEF;
    #1;
    total++;
    if ({bus.io_do_write, bus.io_do_byte_op, bus.io_addr, bus.io_write_data, bus.host_wait} !==
        {1'b1, 1'b0, 15'd100, 16'hBEEF, 1'b0}) begin
      bad++;
      $display("FAIL host_idle got wr=%b addr=%0d data=%h wait=%b want wr=1 addr=100 data=beef wait=0",
               bus.io_do_write, bus.io_addr, bus.io_write_data, bus.host_wait);
    end
    @(posedge clk); #1;
    bus.host_do_write = 1'b0;
    bus.host_addr     = '0;
    bus.host_write_data = '0;
  endtask

  task automatic test_fill();
    int t;
    int d0;
    bit to;
    logic [7:0] vals [0:2];
    vals[0] = 8'h41; vals[1] = 8'h07; vals[2] = 8'h01;
    wr_log.delete();
    d0 = done_cnt;
    issue(1'b0, 15'd0, 15'd0, 13'd2, 8'h41, 8'h07, 8'h01, t);
    total++;
    if ({bus.busy, bus.host_wait, bus.cmd_ready} !== 3'b110) begin
      bad++;
      $display("FAIL fill_busy got busy/wait/ready=%b want=110", {bus.busy, bus.host_wait, bus.cmd_ready});
    end
    wait_ready(40, to);
    total++;
    if (to || done_cyc !== t + 7 || cyc !== t + 8 || done_cnt !== d0 + 1) begin
      bad++;
      $display("FAIL fill_done timeout=%b done_at=%0d ready_at=%0d pulses=%0d want done_at=%0d ready_at=%0d pulses=1",
               to, done_cyc - t, cyc - t, done_cnt - d0, 7, 8);
    end
    total++;
    if (wr_log.size() !== 6) begin
      bad++;
      $display("FAIL fill_count got=%0d want=6", wr_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (wr_log[i].addr !== 15'(i) || wr_log[i].data !== {vals[i % 3], vals[i % 3]} ||
            wr_log[i].cyc !== t + 1 + i || wr_log[i].byte_op !== 1'b1) begin
          bad++;
          $display("FAIL fill_wr%0d got addr=%0d data=%h cyc=T+%0d want addr=%0d data=%h cyc=T+%0d",
                   i, wr_log[i].addr, wr_log[i].data, wr_log[i].cyc - t, i, {vals[i % 3], vals[i % 3]}, i + 1);
        end
      end
    end
  endtask

  task automatic test_copy_up();
    int t;
    bit to;
    for (int i = 0; i < 4; i++) mem[240 + i] = 8'hA0 + 8'(i);
    wr_log.delete();
    issue(1'b1, 15'd0, 15'd240, 13'd4, 8'h00, 8'h00, 8'h00, t);
    total++;
    if ({bus.io_addr, bus.io_do_write, bus.io_do_byte_op} !== {15'd240, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL copy_up_rd got addr=%0d wr=%b byte=%b want addr=240 wr=0 byte=1",
               bus.io_addr, bus.io_do_write, bus.io_do_byte_op);
    end
    wait_ready(60, to);
    total++;
    if (to || done_cyc !== t + 17) begin
      bad++;
      $display("FAIL copy_up_done timeout=%b done_at=T+%0d want T+17", to, done_cyc - t);
    end
    total++;
    if (wr_log.size() !== 4) begin
      bad++;
      $display("FAIL copy_up_count got=%0d want=4", wr_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (wr_log[i].addr !== 15'(i) || wr_log[i].data !== {8'hA0 + 8'(i), 8'hA0 + 8'(i)} ||
            wr_log[i].cyc !== t + 4 * (i + 1) || mem[i] !== 8'hA0 + 8'(i)) begin
          bad++;
          $display("FAIL copy_up_wr%0d got addr=%0d data=%h cyc=T+%0d mem=%h want addr=%0d byte=%h cyc=T+%0d",
                   i, wr_log[i].addr, wr_log[i].data, wr_log[i].cyc - t, mem[i], i, 8'hA0 + 8'(i), 4 * (i + 1));
        end
      end
    end
  endtask

  task automatic test_copy_down();
    int t;
    bit to;
    logic [7:0] exp [0:3];
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33; exp[3] = 8'h44;
    for (int i = 0; i < 4; i++) mem[i] = exp[i];
    wr_log.delete();
    issue(1'b1, 15'd2, 15'd0, 13'd4, 8'h00, 8'h00, 8'h00, t);
    total++;
    if (bus.io_addr !== 15'd3) begin
      bad++;
      $display("FAIL copy_dn_rd got addr=%0d want=3", bus.io_addr);
    end
    wait_ready(60, to);
    total++;
    if (to || done_cyc !== t + 17 || wr_log.size() !== 4) begin
      bad++;
      $display("FAIL copy_dn_done timeout=%b done_at=T+%0d writes=%0d want T+17 writes=4",
               to, done_cyc - t, wr_log.size());
    end else begin
      total++;
      if (wr_log[0].addr !== 15'd5 || wr_log[0].data !== 16'h4444 || wr_log[0].cyc !== t + 4) begin
        bad++;
        $display("FAIL copy_dn_first got addr=%0d data=%h cyc=T+%0d want addr=5 data=4444 cyc=T+4",
                 wr_log[0].addr, wr_log[0].data, wr_log[0].cyc - t);
      end
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (mem[2 + i] !== exp[i]) begin
        bad++;
        $display("FAIL copy_dn_mem%0d got=%h want=%h", 2 + i, mem[2 + i], exp[i]);
      end
    end
  endtask

  task automatic test_err_and_bounds();
    int t;
    int d0;
    int e0;
    bit to;
    wr_log.delete();
    d0 = done_cnt;
    issue(1'b0, 15'd20470, 15'd0, 13'd3, 8'h20, 8'h07, 8'h00, t);
    total++;
    if ({bus.err, bus.done, bus.busy, bus.cmd_ready} !== 4'b1000) begin
      bad++;
      $display("FAIL err_pulse got err/done/busy/ready=%b want=1000",
               {bus.err, bus.done, bus.busy, bus.cmd_ready});
    end
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus.cmd_ready !== 1'b1 || wr_log.size() !== 0 || done_cnt !== d0 || err_cyc !== t + 1) begin
      bad++;
      $display("FAIL err_after ready=%b writes=%0d done_pulses=%0d err_at=T+%0d want 1/0/0/T+1",
               bus.cmd_ready, wr_log.size(), done_cnt - d0, err_cyc - t);
    end
    // Largest legal FILL from the same start: end 20475
    e0 = err_cnt;
    issue(1'b0, 15'd20470, 15'd0, 13'd2, 8'h20, 8'h07, 8'h00, t);
    wait_ready(40, to);
    total++;
    if (to || err_cnt !== e0 || wr_log.size() !== 6 || wr_log[wr_log.size() - 1].addr !== 15'd20475) begin
      bad++;
      $display("FAIL fill_edge timeout=%b errs=%0d writes=%0d want 0/0/6 last=20475", to, err_cnt - e0, wr_log.size());
    end
    wr_log.delete();
    d0 = done_cnt;
    issue(1'b1, 15'd10, 15'd20, 13'd0, 8'h00, 8'h00, 8'h00, t);
    total++;
    if ({bus.done, bus.busy, bus.err} !== 3'b100) begin
      bad++;
      $display("FAIL zero_count got done/busy/err=%b want=100", {bus.done, bus.busy, bus.err});
    end
    wait_ready(10, to);
    total++;
    if (to || wr_log.size() !== 0 || done_cnt !== d0 + 1) begin
      bad++;
      $display("FAIL zero_after timeout=%b writes=%0d pulses=%0d want 0/0/1", to, wr_log.size(), done_cnt - d0);
    end
  endtask

  task automatic test_host_stall();
    int t;
    int n1000;
    bit released;
    wr_log.delete();
    issue(1'b0, 15'd300, 15'd0, 13'd1, 8'h61, 8'h0F, 8'h02, t);
    bus.host_do_write   = 1'b1;
    bus.host_do_byte_op = 1'b0;
    bus.host_addr       = 15'd1000;
    bus.host_write_data = 16'h5A5A;
    #1;
    total++;
    if (bus.host_wait !== 1'b1 || bus.io_addr !== 15'd300) begin
      bad++;
      $display("FAIL stall_hold got wait=%b addr=%0d want wait=1 addr=300", bus.host_wait, bus.io_addr);
    end
    released = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.host_wait === 1'b0) begin
        released = 1'b1;
        break;
      end
    end
    total++;
    if (!released || cyc !== t + 4 || bus.done !== 1'b1 || bus.io_addr !== 15'd1000 ||
        bus.io_do_write !== 1'b1 || bus.io_do_byte_op !== 1'b0) begin
      bad++;
      $display("FAIL stall_release released=%b at=T+%0d done=%b addr=%0d wr=%b byte=%b want 1/T+4/1/1000/1/0",
               released, cyc - t, bus.done, bus.io_addr, bus.io_do_write, bus.io_do_byte_op);
    end
    @(posedge clk); #1;
    bus.host_do_write   = 1'b0;
    bus.host_addr       = '0;
    bus.host_write_data = '0;
    n1000 = 0;
    foreach (wr_log[i]) if (wr_log[i].addr == 15'd1000) n1000++;
    total++;
    if (n1000 !== 1 || wr_log.size() !== 4 || mem[1000] !== 8'h5A || mem[302] !== 8'h02) begin
      bad++;
      $display("FAIL stall_fwd host_writes=%0d total_writes=%0d mem1000=%h mem302=%h want 1/4/5a/02",
               n1000, wr_log.size(), mem[1000], mem[302]);
    end
  endtask

  task automatic test_reset_mid_copy();
    int t;
    int d0;
    bit to;
    d0 = done_cnt;
    issue(1'b1, 15'd600, 15'd240, 13'd4, 8'h00, 8'h00, 8'h00, t);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.busy, bus.done, bus.err, bus.host_wait, bus.io_do_write, bus.io_do_byte_op} !== 6'b0 ||
        bus.io_addr !== 15'd0 || bus.io_write_data !== 16'd0) begin
      bad++;
      $display("FAIL mid_reset flags=%b addr=%0d data=%h want 000000/0/0",
               {bus.busy, bus.done, bus.err, bus.host_wait, bus.io_do_write, bus.io_do_byte_op},
               bus.io_addr, bus.io_write_data);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    wait_ready(2, to);
    total++;
    if (to || done_cnt !== d0) begin
      bad++;
      $display("FAIL mid_reset_after ready_timeout=%b done_pulses=%0d want 0/0", to, done_cnt - d0);
    end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    done_cnt = 0; done_cyc = -1; err_cnt = 0; err_cyc = -1;
    for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
    bus.cmd_valid = 1'b0; bus.cmd_op = 1'b0;
    bus.cmd_dst = '0; bus.cmd_src = '0; bus.cmd_count = '0;
    bus.cmd_char = '0; bus.cmd_fg = '0; bus.cmd_bg = '0;
    bus.host_do_write = 1'b0; bus.host_do_byte_op = 1'b0;
    bus.host_addr = '0; bus.host_write_data = '0;
    test_reset();
    @(posedge clk); #1;
    test_host_idle();
    test_fill();
    test_copy_up();
    test_copy_down();
    test_err_and_bounds();
    test_host_stall();
    test_reset_mid_copy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
